// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO pad boundary.
//   GPIO_WIDTH          - number of pad bits
//   SYNC_STAGES_DEFAULT - default synchronizer depth (must be >= 2)
//   gpio_word_t         - one pad-wide word
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH          = 32;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef logic [GPIO_WIDTH-1:0] gpio_word_t;

endpackage

// File: rtl/gpio_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
//   PCLK    - destination clock, rising edge
//   PRESETn - asynchronous active-low reset, clears every stage
//   d       - asynchronous input
//   q       - synchronized output (last stage)
module gpio_sync_bit
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_pad_modport.sv
// Pad-side boundary of the APB GPIO, PCLK domain.
//   PCLK           - system clock, rising edge
//   PRESETn        - asynchronous active-low reset
//   io_pad         - bidirectional tri-state pad bus
//   io_out         - core output data per bit
//   io_en          - per-bit output enable, 1 = drive pad
//   ext_clk_pad_i  - asynchronous external clock pad
//   in_o           - synchronized pad values
//   rise_o/fall_o  - one-cycle pulses on synchronized 0->1 / 1->0 per bit
//   ext_clk_o      - synchronized external clock
//   ext_clk_rise_o - one-cycle pulse on synchronized external clock rise
module gpio_pad_modport
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    inout  logic [GPIO_WIDTH-1:0] io_pad,
    input  logic [GPIO_WIDTH-1:0] io_out,
    input  logic [GPIO_WIDTH-1:0] io_en,
    input  logic                  ext_clk_pad_i,
    output logic [GPIO_WIDTH-1:0] in_o,
    output logic [GPIO_WIDTH-1:0] rise_o,
    output logic [GPIO_WIDTH-1:0] fall_o,
    output logic                  ext_clk_o,
    output logic                  ext_clk_rise_o
);

    // Bit GPIO_WIDTH of these vectors carries the external clock so that it
    // shares the pad synchronizer and edge-detect path.
    logic [GPIO_WIDTH:0] sync_d;
    logic [GPIO_WIDTH:0] sync_q;
    logic [GPIO_WIDTH:0] prev_q;
    logic [GPIO_WIDTH:0] rise_all;

    // Combinational pad drive; independent of reset.
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
        assign io_pad[i] = io_en[i] ? io_out[i] : 1'bz;
    end

    assign sync_d = {ext_clk_pad_i, io_pad};

    for (genvar i = 0; i < GPIO_WIDTH + 1; i++) begin : g_sync
        gpio_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .PCLK   (PCLK),
            .PRESETn(PRESETn),
            .d      (sync_d[i]),
            .q      (sync_q[i])
        );
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    // Flags are decoded from reset-cleared flops, so they drop as soon as
    // PRESETn asserts.
    assign rise_all       = sync_q & ~prev_q;
    assign in_o           = sync_q[GPIO_WIDTH-1:0];
    assign rise_o         = rise_all[GPIO_WIDTH-1:0];
    assign fall_o         = ~sync_q[GPIO_WIDTH-1:0] & prev_q[GPIO_WIDTH-1:0];
    assign ext_clk_o      = sync_q[GPIO_WIDTH];
    assign ext_clk_rise_o = rise_all[GPIO_WIDTH];

endmodule

// File: tb/tb_gpio_pad_modport.sv
// Scoreboard bench for gpio_pad_modport: stimulus pushes expected values
// tagged with the cycle they must appear; a monitor on the falling edge
// pops and compares them.
module tb_gpio_pad_modport;

    typedef enum logic [2:0] {S_PAD, S_IN, S_RISE, S_FALL, S_EXT, S_EXTR} sel_e;

    typedef struct {
        int unsigned cyc;
        sel_e        sel;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    wire  [31:0] io_pad;
    logic [31:0] io_out;
    logic [31:0] io_en;
    logic        ext_clk_pad_i;
    logic [31:0] in_o;
    logic [31:0] rise_o;
    logic [31:0] fall_o;
    logic        ext_clk_o;
    logic        ext_clk_rise_o;

    logic [31:0] tb_drv;
    logic [31:0] tb_den;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Bench drives every pad bit the DUT is not driving.
    assign tb_den = ~io_en;
    for (genvar i = 0; i < 32; i++) begin : g_tbdrv
        assign io_pad[i] = tb_den[i] ? tb_drv[i] : 1'bz;
    end

    gpio_pad_modport #(
        .SYNC_STAGES(2)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .io_pad        (io_pad),
        .io_out        (io_out),
        .io_en         (io_en),
        .ext_clk_pad_i (ext_clk_pad_i),
        .in_o          (in_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .ext_clk_o     (ext_clk_o),
        .ext_clk_rise_o(ext_clk_rise_o)
    );

    function automatic void check(string name, int unsigned at, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, at, act, exp);
        end
    endfunction

    function automatic void exp_at(int unsigned dly, sel_e s, logic [31:0] m, logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = s;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endfunction

    task automatic next_cyc();
        @(posedge PCLK);
        #2;
    endtask

    // Monitor: compare every entry due this cycle; late entries are failures.
    always @(negedge PCLK) begin
        int unsigned i;
        logic [31:0] act;
        string       nm;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sel)
                    S_PAD:   begin act = io_pad;                nm = "io_pad";         end
                    S_IN:    begin act = in_o;                  nm = "in_o";           end
                    S_RISE:  begin act = rise_o;                nm = "rise_o";         end
                    S_FALL:  begin act = fall_o;                nm = "fall_o";         end
                    S_EXT:   begin act = {31'b0, ext_clk_o};     nm = "ext_clk_o";      end
                    default: begin act = {31'b0, ext_clk_rise_o}; nm = "ext_clk_rise_o"; end
                endcase
                if (sb[i].cyc < cyc) begin
                    check({"late_", nm}, sb[i].cyc, 32'hDEAD_DEAD, sb[i].val);
                end else begin
                    check(nm, cyc, act & sb[i].mask, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        PRESETn       = 1'b0;
        io_en         = '0;
        io_out        = '0;
        tb_drv        = '0;
        ext_clk_pad_i = 1'b0;

        // Reset state
        repeat (3) next_cyc();
        exp_at(0, S_IN,   '1, '0);
        exp_at(0, S_RISE, '1, '0);
        exp_at(0, S_FALL, '1, '0);
        exp_at(0, S_EXT,  '1, '0);
        exp_at(0, S_EXTR, '1, '0);
        next_cyc();
        PRESETn = 1'b1;
        repeat (3) next_cyc();

        // Drive upper half from the core
        io_en  = 32'hFFFF_0000;
        io_out = 32'hA5A5_5A5A;
        tb_drv = 32'h0000_3C3C;
        exp_at(0, S_PAD,  32'hFFFF_0000, 32'hA5A5_0000);
        exp_at(0, S_PAD,  32'h0000_FFFF, 32'h0000_3C3C);
        exp_at(1, S_IN,   '1, '0);
        exp_at(2, S_IN,   '1, 32'hA5A5_3C3C);
        exp_at(2, S_RISE, '1, 32'hA5A5_3C3C);
        exp_at(2, S_FALL, '1, '0);
        exp_at(3, S_RISE, '1, '0);
        repeat (4) next_cyc();
        io_en  = '0;
        io_out = '0;
        tb_drv = '0;
        exp_at(2, S_IN,   '1, '0);
        exp_at(2, S_FALL, '1, 32'hA5A5_3C3C);
        exp_at(3, S_FALL, '1, '0);
        repeat (4) next_cyc();

        // External input pulse of 4 cycles
        tb_drv = 32'h0000_00F0;
        exp_at(1, S_IN,   '1, '0);
        exp_at(2, S_IN,   '1, 32'h0000_00F0);
        exp_at(2, S_RISE, '1, 32'h0000_00F0);
        exp_at(3, S_RISE, '1, '0);
        exp_at(3, S_IN,   '1, 32'h0000_00F0);
        repeat (4) next_cyc();
        tb_drv = '0;
        exp_at(2, S_IN,   '1, '0);
        exp_at(2, S_FALL, '1, 32'h0000_00F0);
        exp_at(2, S_RISE, '1, '0);
        exp_at(3, S_FALL, '1, '0);
        repeat (4) next_cyc();

        // Mixed: bit 0 loopback, toggling every 3 cycles
        io_en  = 32'h1;
        io_out = '0;
        repeat (3) next_cyc();
        for (int t = 0; t < 4; t++) begin
            logic v;
            v = (t % 2 == 0);
            io_out = {31'b0, v};
            exp_at(1, S_IN,   32'h1, {31'b0, !v});
            exp_at(2, S_IN,   32'h1, {31'b0, v});
            exp_at(2, S_RISE, 32'h1, {31'b0, v});
            exp_at(2, S_FALL, 32'h1, {31'b0, !v});
            exp_at(3, S_RISE, 32'h1, '0);
            exp_at(3, S_FALL, 32'h1, '0);
            repeat (3) next_cyc();
        end
        io_en  = '0;
        io_out = '0;
        repeat (4) next_cyc();

        // External clock at PCLK/8
        for (int k = 0; k < 32; k++) begin
            ext_clk_pad_i = ((k % 8) < 4);
            if (k % 8 == 0) begin
                exp_at(2, S_EXT,  '1, 32'h1);
                exp_at(2, S_EXTR, '1, 32'h1);
                for (int unsigned d = 3; d < 8; d++) exp_at(d, S_EXTR, '1, '0);
                exp_at(6, S_EXT,  '1, '0);
            end
            next_cyc();
        end
        repeat (3) next_cyc();

        // Mid-run asynchronous reset
        tb_drv        = '1;
        ext_clk_pad_i = 1'b1;
        exp_at(2, S_IN,   '1, '1);
        exp_at(2, S_RISE, '1, '1);
        exp_at(2, S_EXT,  '1, 32'h1);
        exp_at(2, S_EXTR, '1, 32'h1);
        repeat (2) next_cyc();
        #5;
        PRESETn = 1'b0;
        #1;
        check("rst_in_o",           cyc, in_o,   '0);
        check("rst_rise_o",         cyc, rise_o, '0);
        check("rst_fall_o",         cyc, fall_o, '0);
        check("rst_ext_clk_o",      cyc, {31'b0, ext_clk_o},      '0);
        check("rst_ext_clk_rise_o", cyc, {31'b0, ext_clk_rise_o}, '0);
        repeat (3) next_cyc();

        // Release with pads held high: one rise pulse after the synchronizer
        PRESETn = 1'b1;
        exp_at(1, S_IN,   '1, '0);
        exp_at(2, S_IN,   '1, '1);
        exp_at(2, S_RISE, '1, '1);
        exp_at(2, S_EXTR, '1, 32'h1);
        exp_at(3, S_RISE, '1, '0);
        exp_at(3, S_EXTR, '1, '0);
        repeat (4) next_cyc();

        for (int w = 0; w < 20 && sb.size() != 0; w++) next_cyc();
        while (sb.size() != 0) begin
            check("pending", sb[0].cyc, 32'hDEAD_DEAD, sb[0].val);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
